// File: rtl/macro_pkg.sv
// -----------------------------------------------------------------------------
// macro_pkg
// Shared definitions for the alu_pipe block and its testbench.
//   opcode_e     : 4-bit operation select (values 0..12 legal)
//   ILLEGAL_MIN  : first illegal opcode value (13..15 are illegal)
//   is_illegal() : helper flagging an opcode in the illegal range
// -----------------------------------------------------------------------------
package macro_pkg;

   typedef enum logic [3:0] {
      SEL  = 4'd0,
      INC  = 4'd1,
      DEC  = 4'd2,
      ADD  = 4'd3,
      ADDC = 4'd4,
      SUB  = 4'd5,
      SUBB = 4'd6,
      AND  = 4'd7,
      OR   = 4'd8,
      XOR  = 4'd9,
      NOT  = 4'd10,
      SHL  = 4'd11,
      SHR  = 4'd12
   } opcode_e;

   localparam logic [3:0] ILLEGAL_MIN = 4'd13;

   function automatic logic is_illegal(input logic [3:0] op);
      return (op >= ILLEGAL_MIN);
   endfunction

endpackage

// File: rtl/alu_exec.sv
// -----------------------------------------------------------------------------
// alu_exec
// Purely combinational 4-bit ALU datapath used by alu_pipe.
// Ports:
//   a, b   in  [3:0]    operands
//   cin    in           carry/borrow in (ADDC/SUBB only)
//   ctl    in  opcode_e operation select
//   alu    out [3:0]    result
//   carry  out          carry-out / borrow / shifted-out bit
//   zero   out          alu == 0 (legal ops only)
//   err    out          opcode in the illegal range
// -----------------------------------------------------------------------------
module alu_exec
   import macro_pkg::*;
(
   input  logic [3:0] a,
   input  logic [3:0] b,
   input  logic       cin,
   input  opcode_e    ctl,
   output logic [3:0] alu,
   output logic       carry,
   output logic       zero,
   output logic       err
);

   // Every operation is expressed as a 5-bit word: bit 4 is the carry-type
   // output, bits 3:0 the result. Subtractions wrap in 5 bits, so bit 4 is
   // set exactly when the true difference is negative (a borrow occurred).
   logic [4:0] sum;
   logic       illegal;

   always_comb begin
      // NOTE: defaults assigned before the case keep this block free of
      // inferred latches even for opcodes no branch names.
      sum     = 5'd0;
      illegal = 1'b0;
      case (ctl)
         SEL:  sum = {1'b0, a};
         INC:  sum = {1'b0, a} + 5'd1;
         DEC:  sum = {1'b0, a} - 5'd1;
         ADD:  sum = {1'b0, a} + {1'b0, b};
         ADDC: sum = {1'b0, a} + {1'b0, b} + {4'd0, cin};
         SUB:  sum = {1'b0, a} - {1'b0, b};
         SUBB: sum = {1'b0, a} - {1'b0, b} - {4'd0, cin};
         AND:  sum = {1'b0, a & b};
         OR:   sum = {1'b0, a | b};
         XOR:  sum = {1'b0, a ^ b};
         NOT:  sum = {1'b0, ~a};
         SHL:  sum = {a, 1'b0};
         SHR:  sum = {a[0], 1'b0, a[3:1]};
         default: illegal = 1'b1;   // 13..15: result forced to zero
      endcase
   end

   assign alu   = sum[3:0];
   assign carry = sum[4];
   assign zero  = ~illegal & (sum[3:0] == 4'd0);
   assign err   = illegal;

endmodule

// File: rtl/alu_pipe.sv
// -----------------------------------------------------------------------------
// alu_pipe
// Two-stage pipelined 4-bit ALU. Stage 1 captures the operands, stage 2
// captures the computed result. Latency 2 cycles, one op per cycle, no
// backpressure. Bubbles (valid_in=0) leave result outputs holding.
// Optional feature: define ALU_ERR_CNT_EN to add the saturating 8-bit
// illegal-opcode counter on port err_cnt.
// Ports:
//   clk        in           clock, rising edge
//   reset      in           asynchronous reset, active low
//   valid_in   in           operands/opcode valid
//   a, b       in  [3:0]    operands
//   cin        in           carry/borrow in
//   ctl        in  opcode_e operation select
//   valid_out  out          one pulse per accepted valid_in
//   alu        out [3:0]    result
//   carry      out          carry / borrow / shifted-out bit
//   zero       out          alu == 0 for legal ops
//   err        out          illegal opcode, qualified by valid_out
//   err_cnt    out [7:0]    illegal-op count (ALU_ERR_CNT_EN only)
// -----------------------------------------------------------------------------
module alu_pipe
   import macro_pkg::*;
(
   input  logic       clk,
   input  logic       reset,
   input  logic       valid_in,
   input  logic [3:0] a,
   input  logic [3:0] b,
   input  logic       cin,
   input  opcode_e    ctl,
   output logic       valid_out,
   output logic [3:0] alu,
   output logic       carry,
   output logic       zero,
   output logic       err
`ifdef ALU_ERR_CNT_EN
   ,
   output logic [7:0] err_cnt
`endif
);

   // Stage 1: operand registers.
   logic       s1_valid;
   logic [3:0] s1_a;
   logic [3:0] s1_b;
   logic       s1_cin;
   opcode_e    s1_ctl;

   // Combinational result of the stage-1 operands.
   logic [3:0] x_alu;
   logic       x_carry;
   logic       x_zero;
   logic       x_err;

   // NOTE: sequential state uses non-blocking assignments so every register
   // samples pre-edge values and the two stages shift as one.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         s1_valid <= 1'b0;
      end else begin
         s1_valid <= valid_in;
      end
   end

   // NOTE: data registers are reset as well, not only the valid flags: the
   // outputs must read zero during reset and stage registers must start clean.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         s1_a   <= 4'd0;
         s1_b   <= 4'd0;
         s1_cin <= 1'b0;
         s1_ctl <= SEL;
      end else if (valid_in) begin
         s1_a   <= a;
         s1_b   <= b;
         s1_cin <= cin;
         s1_ctl <= ctl;
      end
   end

   alu_exec u_exec (
      .a     (s1_a),
      .b     (s1_b),
      .cin   (s1_cin),
      .ctl   (s1_ctl),
      .alu   (x_alu),
      .carry (x_carry),
      .zero  (x_zero),
      .err   (x_err)
   );

   // Stage 2: result registers; they hold across bubbles.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         valid_out <= 1'b0;
      end else begin
         valid_out <= s1_valid;
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         alu   <= 4'd0;
         carry <= 1'b0;
         zero  <= 1'b0;
         err   <= 1'b0;
      end else if (s1_valid) begin
         alu   <= x_alu;
         carry <= x_carry;
         zero  <= x_zero;
         err   <= x_err;
      end
   end

`ifdef ALU_ERR_CNT_EN
   // Counts on the same edge that presents the erroring result, so err_cnt
   // already includes the op whose valid_out/err pulse is visible.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         err_cnt <= 8'd0;
      end else if (s1_valid && x_err && (err_cnt != 8'hFF)) begin
         err_cnt <= err_cnt + 8'd1;
      end
   end
`endif

endmodule

// File: tb/tb_alu_pipe.sv
// -----------------------------------------------------------------------------
// tb_alu_pipe
// Self-checking bench for alu_pipe. A behavioural reference computes each
// op with integer arithmetic and models the two-cycle delay and result hold
// with a pending/visible pair of records. Define ALU_ERR_CNT_EN to also
// check the illegal-opcode counter.
// -----------------------------------------------------------------------------
module tb_alu_pipe;
   import macro_pkg::*;

   typedef struct packed {
      logic       v;
      logic [3:0] alu;
      logic       c;
      logic       z;
      logic       e;
   } out_t;

   logic       clk;
   logic       reset;
   logic       valid_in;
   logic [3:0] a;
   logic [3:0] b;
   logic       cin;
   opcode_e    ctl;
   logic       valid_out;
   logic [3:0] alu;
   logic       carry;
   logic       zero;
   logic       err;
`ifdef ALU_ERR_CNT_EN
   logic [7:0] err_cnt;
`endif

   int vectors    = 0;
   int miscompares = 0;

   out_t pend;      // result of the item currently in stage 1
   out_t exp_out;   // expected visible outputs
   int   exp_cnt;

   alu_pipe dut (
      .clk       (clk),
      .reset     (reset),
      .valid_in  (valid_in),
      .a         (a),
      .b         (b),
      .cin       (cin),
      .ctl       (ctl),
      .valid_out (valid_out),
      .alu       (alu),
      .carry     (carry),
      .zero      (zero),
      .err       (err)
`ifdef ALU_ERR_CNT_EN
      ,
      .err_cnt   (err_cnt)
`endif
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic out_t dut_out();
      return {valid_out, alu, carry, zero, err};
   endfunction

   // Reference: ops from the arithmetic definition, no 5-bit tricks.
   function automatic out_t ref_op(input int op, input int x, input int y, input int ci);
      out_t o;
      int   r;
      int   c;
      bit   bad;
      r   = 0;
      c   = 0;
      bad = 0;
      case (op)
         0:  r = x;
         1:  begin r = x + 1;      c = (r > 15); end
         2:  begin r = x - 1;      c = (x == 0); end
         3:  begin r = x + y;      c = (r > 15); end
         4:  begin r = x + y + ci; c = (r > 15); end
         5:  begin r = x - y;      c = (x < y); end
         6:  begin r = x - y - ci; c = (x < y + ci); end
         7:  r = x & y;
         8:  r = x | y;
         9:  r = x ^ y;
         10: r = 15 - x;
         11: begin r = x * 2;      c = x / 8; end
         12: begin r = x / 2;      c = x % 2; end
         default: bad = 1;
      endcase
      o.v   = 1'b1;
      o.alu = 4'(r & 15);
      o.c   = c[0];
      o.z   = !bad && ((r & 15) == 0);
      o.e   = bad;
      return o;
   endfunction

   task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s: observed %h expected %h at %0t", tag, obs, exp, $time);
      end
   endtask

   // Drive one cycle, advance the model, compare everything.
   task automatic cycle(input logic v, input opcode_e op, input logic [3:0] ia,
                        input logic [3:0] ib, input logic ic);
      valid_in = v;
      ctl      = op;
      a        = ia;
      b        = ib;
      cin      = ic;
      @(posedge clk);
      #1;
      if (pend.v) exp_out = pend;
      else        exp_out.v = 1'b0;
      if (v) pend = ref_op(int'(op), int'(ia), int'(ib), int'(ic));
      else   pend = '0;
      if (exp_out.v && exp_out.e && exp_cnt < 255) exp_cnt++;
      check("pipe", dut_out(), exp_out);
`ifdef ALU_ERR_CNT_EN
      check("err_cnt", err_cnt, 8'(exp_cnt));
`endif
   endtask

   task automatic rand_cycle(input logic v, input int max_op);
      cycle(v, opcode_e'(4'($urandom_range(0, max_op))), 4'($urandom), 4'($urandom),
            1'($urandom));
   endtask

   // Assert reset between edges, verify it acts at once, hold n edges with
   // valid_in high, release away from the edge.
   task automatic do_reset(input int n);
      #1;
      reset = 1'b0;
      #1;
      pend    = '0;
      exp_out = '0;
      exp_cnt = 0;
      check("async_rst", dut_out(), 8'h00);
      for (int i = 0; i < n; i++) begin
         valid_in = 1'b1;
         ctl      = ADD;
         a        = 4'($urandom);
         b        = 4'($urandom);
         @(posedge clk);
         #1;
         check("in_rst", dut_out(), 8'h00);
`ifdef ALU_ERR_CNT_EN
         check("rst_cnt", err_cnt, 8'h00);
`endif
      end
      #2;
      reset = 1'b1;
   endtask

   typedef struct {
      opcode_e    op;
      logic [3:0] x;
      logic [3:0] y;
      logic       ci;
      logic [3:0] r;
      logic       c;
      logic       z;
   } dir_t;

   dir_t dirs [6] = '{
      '{ADD,  4'd8, 4'd8, 1'b0, 4'd0,  1'b1, 1'b1},
      '{ADDC, 4'd7, 4'd8, 1'b1, 4'd0,  1'b1, 1'b1},
      '{SUBB, 4'd3, 4'd3, 1'b1, 4'd15, 1'b1, 1'b0},
      '{SHL,  4'd9, 4'd0, 1'b0, 4'd2,  1'b1, 1'b0},
      '{SHR,  4'd9, 4'd0, 1'b0, 4'd4,  1'b1, 1'b0},
      '{XOR,  4'd5, 4'd5, 1'b0, 4'd0,  1'b0, 1'b1}
   };

   initial begin
      reset    = 1'b0;
      valid_in = 1'b1;
      ctl      = SEL;
      a        = 4'd0;
      b        = 4'd0;
      cin      = 1'b0;
      pend     = '0;
      exp_out  = '0;
      exp_cnt  = 0;

      // Reset held 3 cycles with valid_in high, then first op after release.
      do_reset(3);
      cycle(1'b1, INC, 4'd6, 4'd0, 1'b0);
      check("first_lat1", {7'd0, valid_out}, 8'h00);
      cycle(1'b0, SEL, 4'd0, 4'd0, 1'b0);
      check("first_lat2", dut_out(), {1'b1, 4'd7, 1'b0, 1'b0, 1'b0});

      // Directed arithmetic / shift / logic cases, two edges each.
      foreach (dirs[i]) begin
         cycle(1'b1, dirs[i].op, dirs[i].x, dirs[i].y, dirs[i].ci);
         cycle(1'b0, SEL, 4'd0, 4'd0, 1'b0);
         check("directed", dut_out(), {1'b1, dirs[i].r, dirs[i].c, dirs[i].z, 1'b0});
      end

      // Boundary ops: DEC of 0, INC of 15, SUB with borrow, NOT.
      cycle(1'b1, DEC, 4'd0,  4'd0, 1'b0);
      cycle(1'b1, INC, 4'd15, 4'd0, 1'b0);
      cycle(1'b1, SUB, 4'd2,  4'd5, 1'b0);
      cycle(1'b1, NOT, 4'd15, 4'd0, 1'b0);
      cycle(1'b0, SEL, 4'd0,  4'd0, 1'b0);
      cycle(1'b0, SEL, 4'd0,  4'd0, 1'b0);

      // Stream of 10 items with a bubble in slot 4, then drain.
      for (int i = 0; i < 11; i++) rand_cycle(i != 4, 12);
      cycle(1'b0, SEL, 4'd0, 4'd0, 1'b0);
      cycle(1'b0, SEL, 4'd0, 4'd0, 1'b0);

      // Random mix including illegal opcodes and bubbles.
      for (int i = 0; i < 200; i++) rand_cycle(($urandom_range(0, 9) < 8), 15);
      cycle(1'b0, SEL, 4'd0, 4'd0, 1'b0);
      cycle(1'b0, SEL, 4'd0, 4'd0, 1'b0);

      // Two items in flight, reset asserted: neither emerges afterwards.
      cycle(1'b1, ADD, 4'd1, 4'd2, 1'b0);
      cycle(1'b1, ADD, 4'd3, 4'd4, 1'b0);
      do_reset(1);
      for (int i = 0; i < 4; i++) cycle(1'b0, SEL, 4'd0, 4'd0, 1'b0);

      // Three illegal ops back to back.
      for (int i = 0; i < 3; i++) cycle(1'b1, opcode_e'(4'd14), 4'd9, 4'd3, 1'b1);
      cycle(1'b0, SEL, 4'd0, 4'd0, 1'b0);
      check("illegal", dut_out(), {1'b1, 4'd0, 1'b0, 1'b0, 1'b1});
      cycle(1'b0, SEL, 4'd0, 4'd0, 1'b0);
      check("illegal_hold", dut_out(), {1'b0, 4'd0, 1'b0, 1'b0, 1'b1});
`ifdef ALU_ERR_CNT_EN
      check("err_cnt3", err_cnt, 8'd3);
`endif

      // 300 illegal ops drive the counter into saturation.
      for (int i = 0; i < 300; i++)
         cycle(1'b1, opcode_e'(4'($urandom_range(13, 15))), 4'($urandom), 4'($urandom), 1'b0);
      cycle(1'b0, SEL, 4'd0, 4'd0, 1'b0);
      cycle(1'b0, SEL, 4'd0, 4'd0, 1'b0);
`ifdef ALU_ERR_CNT_EN
      check("err_cnt_sat", err_cnt, 8'd255);
`endif

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
